// File: rtl/lebug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lebug_pkg
// Description : Shared constants, entry type and chain-ID width helper for the
//               tracing input buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package lebug_pkg;

    localparam int c_ib_config_id_default = 0;
    localparam int c_ib_n_default         = 8;
    localparam int c_ib_data_width_default = 32;

    typedef struct packed {
        logic                                                      eof;
        logic [c_ib_n_default-1:0][c_ib_data_width_default-1:0]    vector;
    } ib_entry_t;

    // A single-chain build still needs a 1-bit tag port.
    function automatic int chain_id_width(input int max_chains);
        return (max_chains > 2) ? $clog2(max_chains) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ib_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : ib_fifo_core
// Description : Register-array circular FIFO with count-derived full/empty;
//               all DEPTH entries usable, no read/write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module ib_fifo_core #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                  c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_one = 1;
    localparam logic [c_addr_w:0]   c_cnt_one = 1;
    localparam logic [c_addr_w:0]   c_cnt_max = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately unreset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign full    = (r_count == c_cnt_max);
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/trace_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : trace_input_buffer
// Description : Tracing input buffer: FIFO of N-lane vectors with EOF flag,
//               valid/ready output register and round-robin chain tagging.
//               Optional drop counter enabled by macro IB_DROP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_input_buffer
    import lebug_pkg::*;
#(
    parameter int N                = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int IB_DEPTH         = 4,
    parameter int MAX_CHAINS       = 4,
    parameter int INITIAL_FIRMWARE = 0,
    parameter int IB_CONFIG_ID     = c_ib_config_id_default
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  enqueue,
    input  logic                                  eof_in,
    input  logic                                  tracing,
    input  logic [7:0]                            configId,
    input  logic [7:0]                            configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]          vector_in,
    input  logic                                  ready_in,
    output logic                                  valid_out,
    output logic                                  eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]          vector_out,
    output logic [chain_id_width(MAX_CHAINS)-1:0] chainId_out,
    output logic                                  full_out,
    output logic [$clog2(IB_DEPTH):0]             count_out
`ifdef IB_DROP_COUNT_EN
    ,
    output logic [15:0]                           drop_count_out
`endif
);

    localparam int c_cw      = chain_id_width(MAX_CHAINS);
    localparam int c_entry_w = 1 + N * DATA_WIDTH;

    logic                          w_push;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_cfg_hit;
    logic [c_entry_w-1:0]          w_rd_data;
    logic [7:0]                    w_chain_adv;
    logic [7:0]                    w_chain_next;

    logic                          r_valid;
    logic                          r_eof;
    logic [N-1:0][DATA_WIDTH-1:0]  r_vector;
    logic [c_cw-1:0]               r_chain_id;
    logic [7:0]                    r_chain;
    logic [7:0]                    r_valid_chains;

    assign w_push    = enqueue & tracing & ~w_full;
    assign w_pop     = ~w_empty & (~r_valid | ready_in);
    assign w_cfg_hit = (configId == 8'(IB_CONFIG_ID));

    ib_fifo_core #(
        .WIDTH (c_entry_w),
        .DEPTH (IB_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data ({eof_in, vector_in}),
        .rd_data (w_rd_data),
        .count   (count_out),
        .full    (w_full),
        .empty   (w_empty)
    );

    // A reprogram that leaves the counter out of range restarts the sequence.
    always_comb begin
        w_chain_adv = r_chain;
        if (w_pop) begin
            if (r_valid_chains <= 8'd1 || r_chain >= r_valid_chains - 8'd1)
                w_chain_adv = '0;
            else
                w_chain_adv = r_chain + 8'd1;
        end
        w_chain_next = w_chain_adv;
        if (w_cfg_hit && w_chain_adv >= configData)
            w_chain_next = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid        <= 1'b0;
            r_eof          <= 1'b0;
            r_vector       <= '0;
            r_chain_id     <= '0;
            r_chain        <= '0;
            r_valid_chains <= 8'(INITIAL_FIRMWARE);
        end else begin
            if (w_pop) begin
                r_valid    <= 1'b1;
                r_eof      <= w_rd_data[c_entry_w-1];
                r_vector   <= w_rd_data[c_entry_w-2:0];
                r_chain_id <= r_chain[c_cw-1:0];
            end else if (r_valid && ready_in) begin
                r_valid <= 1'b0;
            end
            r_chain <= w_chain_next;
            if (w_cfg_hit) r_valid_chains <= configData;
        end
    end

    assign valid_out   = r_valid;
    assign eof_out     = r_eof;
    assign vector_out  = r_vector;
    assign chainId_out = r_chain_id;
    assign full_out    = w_full;

`ifdef IB_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (configId == 8'(IB_CONFIG_ID + 1)) begin
            r_drop_count <= '0;
        end else if (enqueue && tracing && w_full && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count_out = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_input_buffer
// Description : Scoreboard testbench for trace_input_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_input_buffer;

    localparam int N          = 8;
    localparam int DW         = 32;
    localparam int DEPTH      = 4;
    localparam int MAXC       = 4;
    localparam int INIT_FW    = 0;
    localparam int CFG_ID     = 0;
    localparam int VW         = N * DW;
    localparam logic [7:0] c_idle_id  = 8'hFF;
    localparam logic [7:0] c_clear_id = 8'(CFG_ID + 1);

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  enqueue;
    logic                  eof_in;
    logic                  tracing;
    logic [7:0]            configId;
    logic [7:0]            configData;
    logic [N-1:0][DW-1:0]  vector_in;
    logic                  ready_in;
    logic                  valid_out;
    logic                  eof_out;
    logic [N-1:0][DW-1:0]  vector_out;
    logic [1:0]            chainId_out;
    logic                  full_out;
    logic [2:0]            count_out;
`ifdef IB_DROP_COUNT_EN
    logic [15:0]           drop_count_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [VW:0] sb[$];
    logic [VW:0] m_out;
    int          m_tag;
    logic        m_vout;
    int          m_cnt;
    int          m_chain;
    int          m_vc;
    int          m_drop;

    always #5 clk = ~clk;

    trace_input_buffer #(
        .N                (N),
        .DATA_WIDTH       (DW),
        .IB_DEPTH         (DEPTH),
        .MAX_CHAINS       (MAXC),
        .INITIAL_FIRMWARE (INIT_FW),
        .IB_CONFIG_ID     (CFG_ID)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enqueue     (enqueue),
        .eof_in      (eof_in),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .vector_out  (vector_out),
        .chainId_out (chainId_out),
        .full_out    (full_out),
        .count_out   (count_out)
`ifdef IB_DROP_COUNT_EN
        ,
        .drop_count_out (drop_count_out)
`endif
    );

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_out   = '0;
        m_tag   = 0;
        m_vout  = 1'b0;
        m_cnt   = 0;
        m_chain = 0;
        m_vc    = INIT_FW;
        m_drop  = 0;
    endtask

    task automatic check_outputs();
        chk("valid_out", valid_out, m_vout);
        if (m_vout) begin
            chk("vector_out", vector_out, m_out[VW-1:0]);
            chk("eof_out", eof_out, m_out[VW]);
            chk("chainId_out", chainId_out, m_tag % MAXC);
        end
        chk("count_out", count_out, m_cnt);
        chk("full_out", full_out, (m_cnt == DEPTH));
`ifdef IB_DROP_COUNT_EN
        chk("drop_count_out", drop_count_out, m_drop);
`endif
    endtask

    // One clock: apply inputs, advance the model across the edge, compare.
    task automatic step(input logic e, input logic t, input logic f,
                        input logic [VW-1:0] v, input logic r,
                        input logic [7:0] cid, input logic [7:0] cd);
        logic acc, drp, pop;
        enqueue = e; tracing = t; eof_in = f; vector_in = v;
        ready_in = r; configId = cid; configData = cd;
        @(posedge clk);
        #1;
        acc = e && t && (m_cnt < DEPTH);
        drp = e && t && (m_cnt == DEPTH);
        pop = (m_cnt != 0) && (!m_vout || r);
        if (pop) begin
            m_out  = sb.pop_front();
            m_tag  = m_chain;
            m_vout = 1'b1;
            m_chain = (m_vc <= 1 || m_chain >= m_vc - 1) ? 0 : m_chain + 1;
        end else if (m_vout && r) begin
            m_vout = 1'b0;
        end
        if (acc) sb.push_back({f, v});
        m_cnt = m_cnt + int'(acc) - int'(pop);
        if (cid == 8'(CFG_ID)) begin
            m_vc = cd;
            if (m_chain >= m_vc) m_chain = 0;
        end
        if (cid == c_clear_id) m_drop = 0;
        else if (drp && m_drop != 16'hFFFF) m_drop++;
        check_outputs();
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic push(input logic r);
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_vec(), r, c_idle_id, 8'h00);
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, r, c_idle_id, 8'h00);
    endtask

    initial begin
        logic [VW-1:0] seq_vec;
        reset_n = 1'b0; enqueue = 1'b0; eof_in = 1'b0; tracing = 1'b0;
        configId = c_idle_id; configData = 8'h00; vector_in = '0; ready_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_vector", vector_out, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single vector {0..7} with EOF
        for (int i = 0; i < N; i++) seq_vec[i*DW +: DW] = DW'(i);
        step(1'b1, 1'b1, 1'b1, seq_vec, 1'b1, c_idle_id, 8'h00);
        idle(1'b1, 3);
        chk("single_drained", count_out, 0);

        // Fill and overflow under stalled consumer; tracing=0 is ignored
        for (int i = 0; i < 6; i++) push(1'b0);
        step(1'b1, 1'b0, 1'b0, rand_vec(), 1'b0, c_idle_id, 8'h00);
        chk("overflow_full", full_out, 1);
        chk("overflow_count", count_out, DEPTH);
        idle(1'b1, 8);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, c_clear_id, 8'h00);

        // Backpressure: ready toggles under continuous push
        for (int i = 0; i < 16; i++) push(1'(i % 2));
        idle(1'b1, 8);

        // Wrap-around at full rate
        for (int i = 0; i < 20; i++) push(1'b1);
        idle(1'b1, 8);

        // Chain tags: 3 chains, then reprogram to 2 with counter at 2
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, 8'(CFG_ID), 8'd3);
        for (int i = 0; i < 5; i++) push(1'b1);
        idle(1'b1, 4);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, 8'(CFG_ID), 8'd2);
        for (int i = 0; i < 3; i++) push(1'b1);
        idle(1'b1, 4);

        // Reset mid-stream with count=3 and valid_out=1
        for (int i = 0; i < 4; i++) push(1'b0);
        chk("pre_reset_count", count_out, 3);
        chk("pre_reset_valid", valid_out, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_vector_mid", vector_out, 0);
        chk("reset_eof_mid", eof_out, 0);
        chk("reset_tag_mid", chainId_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(1'b1);
        idle(1'b1, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
